// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind uart_rx: drops framing-error bytes and
// reports occupancy, sticky error flags and whether a complete line is buffered.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [DATA_WIDTH-1:0] NEWLINE = DATA_WIDTH'(8'h0A)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_valid,
    input  logic                  uart_rx_err,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  line_avail,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  clr_flags
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      nl_count;

    logic good_byte;
    logic push;
    logic pop;
    logic nl_in;
    logic nl_out;
    logic overflow_set;
    logic frame_err_set;

    // Status is a pure decode of the registered counters.
    assign empty      = (count == CNT_W'(0));
    assign full       = (count == CNT_W'(DEPTH));
    assign line_avail = (nl_count != CNT_W'(0));
    assign rd_data    = mem[rd_ptr];

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign good_byte     = uart_rx_valid & ~uart_rx_err;
    assign pop           = rd_en & ~empty;
    assign push          = good_byte & (~full | pop);
    assign nl_in         = push & (uart_rx_data == NEWLINE);
    assign nl_out        = pop & (rd_data == NEWLINE);
    assign overflow_set  = good_byte & full & ~pop;
    assign frame_err_set = uart_rx_valid & uart_rx_err;

    // Storage is intentionally left unreset; only pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Number of buffered terminators; nonzero means a whole line can be read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nl_count <= '0;
        end else begin
            unique case ({nl_in, nl_out})
                2'b10:   nl_count <= nl_count + CNT_W'(1);
                2'b01:   nl_count <= nl_count - CNT_W'(1);
                default: nl_count <= nl_count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= overflow_set  | (overflow  & ~clr_flags);
            frame_err <= frame_err_set | (frame_err & ~clr_flags);
        end
    end

endmodule
